hadamard_stream: RTL and testbench
==================================

// Module: hadamard_stream
// PURPOSE
//  Streaming complex Walsh-Hadamard transform of NPTS = 2**LOG2N points, the parametrised
//  successor of the 2-point add/sub butterfly. Collects one frame of complex samples
//  through a valid/ready input. Runs LOG2N in-place butterfly stages, one stage per clock.
//  Streams the frame out in natural Hadamard order with valid/ready and a last marker.
// PARAMETERS
//  W      8  signed two's-complement width of each input real/imag part
//  LOG2N  2  log2 of frame length; NPTS = 2**LOG2N (LOG2N >= 1)
//  OW     localparam; W+LOG2N without HADAMARD_SCALE_EN, W with it
// PORTS
//  clk        in   1     single clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     input sample valid
//  in_ready   out  1     block accepts a sample this cycle
//  in_re      in   W     input real part, signed
//  in_im      in   W     input imag part, signed
//  out_valid  out  1     output sample valid
//  out_ready  in   1     downstream accepts output
//  out_re     out  OW    output real part, signed
//  out_im     out  OW    output imag part, signed
//  out_last   out  1     high with the final (index NPTS-1) output of a frame
// BEHAVIOUR
//  - Reset: state=LOAD, index counter=0, buffer=0, in_ready=0 during reset then 1, out_valid=0,
//    out_re/out_im=0, out_last=0. Reset is honoured in any state; a partial frame is discarded.
//  - FSM: LOAD -> COMPUTE -> UNLOAD -> LOAD.
//  - LOAD: in_ready=1; each in_valid&&in_ready writes buf[idx], idx++.
//    Handshake on idx=NPTS-1 -> COMPUTE, idx=0, stage=0.
//  - COMPUTE: in_ready=0, out_valid=0. Each cycle performs stage s on all pairs
//    (i, i+2**s), bit s of i = 0: buf[i]<=a+b, buf[i+2**s]<=a-b, real and imag independently.
//    After s=LOG2N-1 -> UNLOAD. Exactly LOG2N cycles.
//  - UNLOAD: out_valid=1, out_* = buf[idx], out_last=(idx==NPTS-1).
//    Outputs are registered and held stable while out_valid && !out_ready.
//    Handshake advances idx; the final handshake -> LOAD, idx=0, in_ready=1 next cycle.
//  - Latency: first out_valid rises LOG2N+1 clocks after the clock of the last input handshake.
//    The block accepts no input outside LOAD; there is no frame overlap.
//  - Arithmetic: signed, sign-extended. Buffer width is OW+0 intermediate as needed so no overflow
//    is possible without scaling: |result| <= NPTS*2**(W-1) fits W+LOG2N bits exactly.
//  - Output order: natural Hadamard (Sylvester) order, out[k] = sum_n (-1)**popcount(n&k) x[n].
//  - in_valid with in_ready=0 is ignored; the data is not captured.
//  - Simultaneous events: none possible on the buffer; the FSM gates input vs output.
// CONFIGURATION
//  HADAMARD_SCALE_EN defined: every stage result is computed at W+1 bits,
//    then arithmetic-shifted right by 1 (floor) back to W bits; OW=W. Output = floor-scaled
//    transform, total scaling ~1/NPTS; no overflow.
//  Not defined: no scaling, growth of 1 bit per stage, OW=W+LOG2N.
// TESTING (W=8, LOG2N=2 unless stated)
//  1 Frame re={1,2,3,4}, im=0, out_ready=1 -> out_re={10,-2,-4,0}, im=0;
//    out_last only on the 4th output; first out_valid 3 clocks after the last input.
//  2 All inputs re=127, im=-128 -> out[0]=(508,-512), out[1..3]=(0,0); no wrap at OW=10.
//  3 Test 1 with out_ready toggling 1,0,0,1,... -> values held stable while stalled.
//    Same sequence {10,-2,-4,0}; in_ready stays 0 until after the 4th handshake.
//  4 Assert rst_n=0 after 2 inputs, release, then send {5,0,0,0}
//    -> outputs {5,5,5,5}; no residue of the aborted frame.
//  5 HADAMARD_SCALE_EN, input {1,2,3,4} -> out_re={2,-1,-1,0} (floor per stage), OW=8.
//  6 LOG2N=3, impulse re={1,0,...,0} -> eight outputs re=1;
//    back-to-back second frame with im={0,1,0,...} -> im={1,-1,1,-1,1,-1,1,-1}.

Source files
------------

// File: rtl/hadamard_stream.sv
`default_nettype none
// hadamard_stream: streaming complex Walsh-Hadamard transform (LOAD -> LOG2N butterfly stages -> UNLOAD).
// Define HADAMARD_SCALE_EN to halve every stage result (floor) and keep the output at W bits.
module hadamard_stream #(
   parameter int W     = 8,
   parameter int LOG2N = 2,
`ifdef HADAMARD_SCALE_EN
   localparam int OW   = W
`else
   localparam int OW   = W + LOG2N
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_re,
   input  logic [W-1:0]  in_im,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_re,
   output logic [OW-1:0] out_im,
   output logic          out_last
);
   localparam int               NPTS      = 2**LOG2N;
   localparam int               SW        = $clog2(LOG2N + 1);
   localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(NPTS - 1);
   localparam logic [SW-1:0]    LAST_STG  = SW'(LOG2N - 1);
   localparam logic [1:0]       S_LOAD    = 2'd0;
   localparam logic [1:0]       S_COMPUTE = 2'd1;
   localparam logic [1:0]       S_UNLOAD  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [LOG2N-1:0] idx_q, idx_d;
   logic [SW-1:0]    stage_q, stage_d;
   logic [OW-1:0]    re_q [NPTS];
   logic [OW-1:0]    re_d [NPTS];
   logic [OW-1:0]    im_q [NPTS];
   logic [OW-1:0]    im_d [NPTS];
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [OW-1:0]    out_re_q, out_re_d;
   logic [OW-1:0]    out_im_q, out_im_d;
   logic [LOG2N-1:0] stage_mask;
   logic [LOG2N-1:0] idx_inc;
   logic             in_fire;
   logic             out_fire;

   // Two's-complement add/sub; the scaled variant keeps the carry bit before halving.
   function automatic logic [OW-1:0] bfly(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic sub);
`ifdef HADAMARD_SCALE_EN
      logic signed [OW:0] ax, bx, s;
      ax = {a[OW-1], a};
      bx = {b[OW-1], b};
      s  = sub ? (ax - bx) : (ax + bx);
      return s[OW:1];
`else
      return sub ? (a - b) : (a + b);
`endif
   endfunction

   assign in_fire    = in_valid && in_ready_q;
   assign out_fire   = out_valid_q && out_ready;
   assign stage_mask = LOG2N'(1) << stage_q;
   assign idx_inc    = idx_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:    if (in_fire && idx_q == LAST_IDX)  state_d = S_COMPUTE;
         S_COMPUTE: if (stage_q == LAST_STG)           state_d = S_UNLOAD;
         S_UNLOAD:  if (out_fire && idx_q == LAST_IDX) state_d = S_LOAD;
         default:                                      state_d = S_LOAD;
      endcase
   end

   always_comb begin
      idx_d       = idx_q;
      stage_d     = stage_q;
      re_d        = re_q;
      im_d        = im_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      in_ready_d  = (state_d == S_LOAD);
      case (state_q)
         S_LOAD: begin
            if (in_fire) begin
               re_d[idx_q] = OW'($signed(in_re));
               im_d[idx_q] = OW'($signed(in_im));
               idx_d       = (idx_q == LAST_IDX) ? '0 : idx_inc;
               stage_d     = '0;
            end
         end
         S_COMPUTE: begin
            // Element i pairs with i^2**s; the lower one takes the sum, the upper the difference.
            for (int i = 0; i < NPTS; i++) begin
               if ((LOG2N'(i) & stage_mask) == '0) begin
                  re_d[i] = bfly(re_q[i], re_q[LOG2N'(i) ^ stage_mask], 1'b0);
                  im_d[i] = bfly(im_q[i], im_q[LOG2N'(i) ^ stage_mask], 1'b0);
               end else begin
                  re_d[i] = bfly(re_q[LOG2N'(i) ^ stage_mask], re_q[i], 1'b1);
                  im_d[i] = bfly(im_q[LOG2N'(i) ^ stage_mask], im_q[i], 1'b1);
               end
            end
            stage_d = stage_q + 1'b1;
            idx_d   = '0;
         end
         S_UNLOAD: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_re_d    = re_q[idx_q];
               out_im_d    = im_q[idx_q];
               out_last_d  = (idx_q == LAST_IDX);
            end else if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_re_d    = '0;
                  out_im_d    = '0;
                  idx_d       = '0;
               end else begin
                  idx_d      = idx_inc;
                  out_re_d   = re_q[idx_inc];
                  out_im_d   = im_q[idx_inc];
                  out_last_d = (idx_inc == LAST_IDX);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         stage_q     <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
         for (int i = 0; i < NPTS; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else begin
         idx_q       <= idx_d;
         stage_q     <= stage_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
         re_q        <= re_d;
         im_q        <= im_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;

endmodule
`default_nettype wire

// File: tb/tb_hadamard_stream.sv
`default_nettype none
// tb_hadamard_stream: table-driven scoreboard bench for a 4-point and an 8-point instance.
module tb_hadamard_stream;
   localparam int W  = 8;
   localparam int NV = 8;
`ifdef HADAMARD_SCALE_EN
   localparam int OW2 = W;
   localparam int OW3 = W;
`else
   localparam int OW2 = W + 2;
   localparam int OW3 = W + 3;
`endif

   typedef struct packed {
      logic [3:0]       n;
      logic [7:0][15:0] xr;
      logic [7:0][15:0] xi;
      logic [7:0][15:0] er;
      logic [7:0][15:0] ei;
   } vec_t;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, sel, in_valid, out_ready;
   logic [W-1:0]   in_re, in_im;
   logic           iv2, iv3, ir2, ir3, ov2, ov3, ol2, ol3;
   logic [OW2-1:0] re2, im2;
   logic [OW3-1:0] re3, im3;
   logic           in_ready_m, o_valid, o_last;
   logic signed [15:0] o_re, o_im;

   assign iv2        = in_valid && !sel;
   assign iv3        = in_valid && sel;
   assign in_ready_m = sel ? ir3 : ir2;
   assign o_valid    = sel ? ov3 : ov2;
   assign o_last     = sel ? ol3 : ol2;
   assign o_re       = sel ? 16'($signed(re3)) : 16'($signed(re2));
   assign o_im       = sel ? 16'($signed(im3)) : 16'($signed(im2));

   hadamard_stream #(.W(W), .LOG2N(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_re(in_re), .in_im(in_im),
      .out_valid(ov2), .out_ready(out_ready), .out_re(re2), .out_im(im2), .out_last(ol2));

   hadamard_stream #(.W(W), .LOG2N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .in_re(in_re), .in_im(in_im),
      .out_valid(ov3), .out_ready(out_ready), .out_re(re3), .out_im(im3), .out_last(ol3));

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   t_last;
   exp_t sb[$];
   vec_t tbl[NV];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0][15:0] p8(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
      logic [7:0][15:0] r;
      r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
      r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
      return r;
   endfunction

   // Scaled build: reference is the transform with a floor halving after every stage.
   function automatic logic [7:0][15:0] scaled_ref(input logic [7:0][15:0] x, input int n);
      int b[8];
      int a, c;
      logic [7:0][15:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) b[i] = $signed(x[i]);
      for (int s = 1; s < n; s = s * 2)
         for (int i = 0; i < n; i++)
            if ((i & s) == 0) begin
               a = b[i]; c = b[i+s];
               b[i]   = (a + c) >>> 1;
               b[i+s] = (a - c) >>> 1;
            end
      for (int i = 0; i < n; i++) r[i] = 16'(b[i]);
      return r;
   endfunction

   // Output monitor: pop/compare on every handshake, verify outputs hold across a stall.
   logic               held_v;
   logic signed [15:0] hre, him;
   logic               hl;
   exp_t               e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (held_v) begin
            chk("hold_valid", int'(o_valid), 1);
            chk("hold_re", o_re, hre);
            chk("hold_im", o_im, him);
            chk("hold_last", int'(o_last), int'(hl));
            held_v = 1'b0;
         end
         if (o_valid) begin
            chk("in_ready_during_unload", int'(in_ready_m), 0);
            if (out_ready) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_output: got re=%0d im=%0d expected no output", o_re, o_im);
               end else begin
                  e = sb.pop_front();
                  chk("out_re", o_re, $signed(e.re));
                  chk("out_im", o_im, $signed(e.im));
                  chk("out_last", int'(o_last), int'(e.last));
               end
            end else begin
               held_v = 1'b1;
               hre = o_re; him = o_im; hl = o_last;
            end
         end
      end
   end

   task automatic put(input logic [15:0] r, input logic [15:0] i);
      int c;
      in_valid = 1'b1; in_re = r[7:0]; in_im = i[7:0];
      c = 0;
      @(negedge clk);
      while (!in_ready_m && c < 300) begin
         @(negedge clk);
         c++;
      end
      if (!in_ready_m) begin
         total++; bad++;
         $display("FAIL put_timeout: got in_ready=0 expected 1 within 300 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      t_last   = cyc;
   endtask

   task automatic send(input vec_t v);
      exp_t x;
      sel = (v.n == 4'd8);
      for (int k = 0; k < int'(v.n); k++) put(v.xr[k], v.xi[k]);
      for (int k = 0; k < int'(v.n); k++) begin
         x.re = v.er[k]; x.im = v.ei[k]; x.last = (k == int'(v.n) - 1);
         sb.push_back(x);
      end
   endtask

   task automatic drain(input bit stall);
      int c, k;
      c = 0; k = 0;
      while ((sb.size() != 0 || o_valid) && c < 500) begin
         @(posedge clk); #1;
         if (stall) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            k++;
         end
         c++;
      end
      if (c >= 500) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      out_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
      out_ready = 1'b1; held_v = 1'b0;

      tbl[0] = '{n:4, xr:p8(1,2,3,4,0,0,0,0), xi:p8(0,0,0,0,0,0,0,0),
                 er:p8(10,-2,-4,0,0,0,0,0), ei:p8(0,0,0,0,0,0,0,0)};
      tbl[1] = '{n:4, xr:p8(127,127,127,127,0,0,0,0), xi:p8(-128,-128,-128,-128,0,0,0,0),
                 er:p8(508,0,0,0,0,0,0,0), ei:p8(-512,0,0,0,0,0,0,0)};
      tbl[2] = '{n:4, xr:p8(5,0,0,0,0,0,0,0), xi:p8(0,0,0,-3,0,0,0,0),
                 er:p8(5,5,5,5,0,0,0,0), ei:p8(-3,3,3,-3,0,0,0,0)};
      tbl[3] = '{n:4, xr:p8(-128,127,-128,127,0,0,0,0), xi:p8(10,20,30,40,0,0,0,0),
                 er:p8(-2,-510,0,0,0,0,0,0), ei:p8(100,-20,-40,0,0,0,0,0)};
      tbl[4] = '{n:8, xr:p8(1,0,0,0,0,0,0,0), xi:p8(0,0,0,0,0,0,0,0),
                 er:p8(1,1,1,1,1,1,1,1), ei:p8(0,0,0,0,0,0,0,0)};
      tbl[5] = '{n:8, xr:p8(0,0,0,0,0,0,0,0), xi:p8(0,1,0,0,0,0,0,0),
                 er:p8(0,0,0,0,0,0,0,0), ei:p8(1,-1,1,-1,1,-1,1,-1)};
      tbl[6] = '{n:8, xr:p8(1,2,3,4,5,6,7,8), xi:p8(0,0,0,0,0,0,0,0),
                 er:p8(36,-4,-8,0,-16,0,0,0), ei:p8(0,0,0,0,0,0,0,0)};
      tbl[7] = '{n:8, xr:p8(-128,-128,-128,-128,-128,-128,-128,-128),
                 xi:p8(127,127,127,127,127,127,127,127),
                 er:p8(-1024,0,0,0,0,0,0,0), ei:p8(1016,0,0,0,0,0,0,0)};
`ifdef HADAMARD_SCALE_EN
      for (int t = 0; t < NV; t++) begin
         tbl[t].er = scaled_ref(tbl[t].xr, int'(tbl[t].n));
         tbl[t].ei = scaled_ref(tbl[t].xi, int'(tbl[t].n));
      end
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready4", int'(ir2), 0);
      chk("rst_in_ready8", int'(ir3), 0);
      chk("rst_out_valid", int'(ov2), 0);
      chk("rst_out_re", $signed(re2), 0);
      chk("rst_out_last", int'(ol2), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_reset", int'(ir2), 1);

      for (int t = 0; t < NV; t++) begin
         send(tbl[t]);
         drain(1'b0);
      end

      // First out_valid must rise LOG2N+1 clocks after the last input handshake.
      send(tbl[0]);
      c = 0;
      while (!o_valid && c < 20) begin
         @(posedge clk); #1;
         chk("in_ready_during_compute", int'(in_ready_m), 0);
         c++;
      end
      chk("latency4", cyc - t_last, 3);
      drain(1'b0);

      // Stalled unload: values must hold, order unchanged, input closed until the end.
      send(tbl[0]);
      drain(1'b1);
      @(posedge clk); #1;
      chk("in_ready_after_stall_frame", int'(ir2), 1);

      // Back-to-back 8-point frames.
      send(tbl[4]);
      send(tbl[5]);
      drain(1'b0);

      // Reset mid-frame: the partial frame must leave no residue.
      sel = 1'b0;
      put(16'd77, 16'd9);
      put(16'd33, 16'd9);
      rst_n = 1'b0;
      #2;
      chk("abort_in_ready", int'(ir2), 0);
      chk("abort_out_valid", int'(ov2), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(tbl[2]);
      drain(1'b0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
